// File: rtl/instr_fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue slice: default widths and depth.
package instr_fetch_queue_pkg;
  localparam int PC_WIDTH   = 32;
  localparam int INST_WIDTH = 32;
  localparam int IFQ_DEPTH  = 4;

  // Width of a counter that must hold every value 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_flush.sv
// Synchronous FIFO with single-cycle clear; push is accepted when full if a pop happens the same cycle.
module sync_fifo_flush
  import instr_fetch_queue_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch queue: issues in-order imem reads for the PC stream and buffers {data, pc} for decode.
// Optional same-cycle response bypass to decode is enabled by defining IFQ_BYPASS_EN.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int PC_W   = PC_WIDTH,
  parameter int INST_W = INST_WIDTH,
  parameter int DEPTH  = IFQ_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              pc_valid,
  output logic              pc_stall,
  input  logic              flush,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [PC_W-1:0]   inst_pc
);
  localparam int CW = cnt_width(DEPTH);
  localparam int UW = CW + 2;

  // Handshakes: a transfer happens on a cycle where both sides are high (req&gnt, valid&ready);
  // req/valid never depend on gnt/ready of the same cycle, and rvalid is unconditional.
  logic [CW-1:0]          outs_q, outs_d, drop_q, drop_d;
  logic [CW-1:0]          q_count, pcf_count;
  logic                   q_full, q_empty, pcf_full, pcf_empty;
  logic [PC_W-1:0]        pcf_head;
  logic [INST_W+PC_W-1:0] q_head;
  logic [UW-1:0]          used;
  logic                   credit, issue, resp_keep, resp_drop, byp, q_push, q_pop;

  assign used      = UW'(q_count) + UW'(outs_q) + UW'(drop_q);
  assign credit    = (used < UW'(DEPTH));
  assign imem_req  = pc_valid & credit & ~flush;
  assign imem_addr = pc_in;
  assign issue     = imem_req & imem_gnt;
  assign pc_stall  = pc_valid & ~issue;
  assign resp_drop = imem_rvalid & (drop_q != '0);
  assign resp_keep = imem_rvalid & (drop_q == '0) & ~flush;

`ifdef IFQ_BYPASS_EN
  assign byp = resp_keep & q_empty;
`else
  assign byp = 1'b0;
`endif

  assign inst_valid = ~q_empty | byp;
  assign inst_data  = byp ? imem_rdata : q_head[PC_W +: INST_W];
  assign inst_pc    = byp ? pcf_head   : q_head[PC_W-1:0];
  assign q_pop      = ~q_empty & inst_ready & ~flush;
  // A bypassed word taken by decode this cycle never enters the queue.
  assign q_push     = resp_keep & ~(byp & inst_ready);

  always_comb begin
    outs_d = outs_q;
    drop_d = drop_q;
    if (flush) begin
      outs_d = '0;
      drop_d = drop_q + outs_q - CW'(imem_rvalid);
    end else begin
      outs_d = outs_q + CW'(issue) - CW'(resp_keep);
      drop_d = drop_q - CW'(resp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outs_q <= '0;
      drop_q <= '0;
    end else begin
      outs_q <= outs_d;
      drop_q <= drop_d;
    end
  end

  sync_fifo_flush #(.W(PC_W), .DEPTH(DEPTH)) u_pc_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (issue),
    .din   (pc_in),
    .pop   (resp_keep),
    .dout  (pcf_head),
    .full  (pcf_full),
    .empty (pcf_empty),
    .count (pcf_count)
  );

  sync_fifo_flush #(.W(INST_W + PC_W), .DEPTH(DEPTH)) u_inst_q (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (q_push),
    .din   ({imem_rdata, pcf_head}),
    .pop   (q_pop),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (outs_q != '0 || drop_q != '0));
  a_pcf_tracks_outs: assert property (@(posedge clk) disable iff (rst)
    pcf_count == outs_q);
  a_no_issue_full: assert property (@(posedge clk) disable iff (rst)
    issue |-> !pcf_full);
  a_keep_has_pc: assert property (@(posedge clk) disable iff (rst)
    resp_keep |-> !pcf_empty);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    q_push |-> (!q_full || q_pop));
endmodule
